// File: rtl/iterative_multiply_divide.sv
// Multi-cycle signed MUL/MULH/DIV/REM unit: one bit per clock, with a one-cycle done pulse.
// Define MULDIV_DIVIDER_EN to build the divider; without it DIV/REM return illegal.
module iterative_multiply_divide #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 2
) (
    input  logic                  _clock,
    input  logic                  _reset,
    input  logic                  _start,
    input  logic [OP_WIDTH-1:0]   _op,
    input  logic [DATA_WIDTH-1:0] _valA,
    input  logic [DATA_WIDTH-1:0] _valB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  divZero,
    output logic                  illegal
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_MULH = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_DIV  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_REM  = OP_WIDTH'(3);
`ifdef MULDIV_DIVIDER_EN
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [OP_WIDTH-1:0] op_q, op_d;
    logic                neg_q, neg_d;
    logic [W:0]          mag_b_q, mag_b_d;
    logic [W:0]          acc_q, acc_d;
    logic [W-1:0]        lo_q, lo_d;
    logic [W-1:0]        result_q, result_d;
    logic                overflow_q, overflow_d;
    logic                div_zero_q, div_zero_d;
    logic                illegal_q, illegal_d;
`ifdef MULDIV_DIVIDER_EN
    logic                rem_neg_q, rem_neg_d;
    logic [W:0]          shifted;
`endif

    logic [W-1:0]   mag_a;
    logic [W:0]     b_ext;
    logic [W:0]     sum;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] sprod;
    logic           is_div_op;

    always_comb begin
        mag_a     = _valA[W-1] ? -_valA : _valA;
        b_ext     = {_valB[W-1], _valB};
        is_div_op = (_op == OP_DIV) || (_op == OP_REM);
        sum       = acc_q + (lo_q[0] ? mag_b_q : '0);
        prod      = {acc_q[W-1:0], lo_q};
        sprod     = neg_q ? -prod : prod;
`ifdef MULDIV_DIVIDER_EN
        shifted   = {acc_q[W-1:0], lo_q[W-1]};
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_d      = neg_q;
        mag_b_d    = mag_b_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        div_zero_d = div_zero_q;
        illegal_d  = illegal_q;
`ifdef MULDIV_DIVIDER_EN
        rem_neg_d  = rem_neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (_start) begin
                    overflow_d = 1'b0;
                    div_zero_d = 1'b0;
                    illegal_d  = 1'b0;
                    op_d       = _op;
                    neg_d      = _valA[W-1] ^ _valB[W-1];
                    lo_d       = mag_a;
                    mag_b_d    = _valB[W-1] ? -b_ext : b_ext;
                    acc_d      = '0;
                    cnt_d      = CW'(W - 1);
                    state_d    = S_RUN;
`ifdef MULDIV_DIVIDER_EN
                    rem_neg_d  = _valA[W-1];
                    if (is_div_op) begin
                        if (_valB == '0) begin
                            state_d    = S_DONE;
                            div_zero_d = 1'b1;
                            result_d   = (_op == OP_DIV) ? '1 : _valA;
                        end else if (_valA == MIN_VAL && _valB == '1) begin
                            state_d    = S_DONE;
                            overflow_d = (_op == OP_DIV);
                            result_d   = (_op == OP_DIV) ? MIN_VAL : '0;
                        end
                    end
`else
                    if (is_div_op) begin
                        state_d   = S_DONE;
                        illegal_d = 1'b1;
                        result_d  = '0;
                    end
`endif
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_FIX;
`ifdef MULDIV_DIVIDER_EN
                if (op_q == OP_DIV || op_q == OP_REM) begin
                    // Restoring step: remainder in acc, dividend shifts out of lo as quotient shifts in.
                    if (shifted >= mag_b_q) begin
                        acc_d = shifted - mag_b_q;
                        lo_d  = {lo_q[W-2:0], 1'b1};
                    end else begin
                        acc_d = shifted;
                        lo_d  = {lo_q[W-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {1'b0, sum[W:1]};
                    lo_d  = {sum[0], lo_q[W-1:1]};
                end
`else
                acc_d = {1'b0, sum[W:1]};
                lo_d  = {sum[0], lo_q[W-1:1]};
`endif
            end
            S_FIX: begin
                state_d = S_DONE;
                case (op_q)
                    OP_MUL: begin
                        result_d   = sprod[W-1:0];
                        overflow_d = sprod[2*W-1:W] != {W{sprod[W-1]}};
                    end
                    OP_MULH: result_d = sprod[2*W-1:W];
`ifdef MULDIV_DIVIDER_EN
                    OP_DIV:  result_d = neg_q ? -lo_q : lo_q;
                    OP_REM:  result_d = rem_neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
`endif
                    default: ;
                endcase
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            mag_b_q    <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef MULDIV_DIVIDER_EN
            rem_neg_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            mag_b_q    <= mag_b_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            div_zero_q <= div_zero_d;
            illegal_q  <= illegal_d;
`ifdef MULDIV_DIVIDER_EN
            rem_neg_q  <= rem_neg_d;
`endif
        end
    end

    assign busy     = (state_q == S_RUN) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign overflow = overflow_q;
    assign divZero  = div_zero_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_iterative_multiply_divide.sv
// Bench for iterative_multiply_divide: fixed vectors, hand sequences, and random ops against an integer model.
module tb_iterative_multiply_divide;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [1:0] op;
    logic [7:0] va, vb;
    logic       busy, done, overflow, div_zero, illegal;
    logic [7:0] result;

    int errors = 0;
    int checks = 0;

    iterative_multiply_divide #(.DATA_WIDTH(8), .OP_WIDTH(2)) dut (
        ._clock(clk), ._reset(rst), ._start(start), ._op(op), ._valA(va), ._valB(vb),
        .busy(busy), .done(done), .result(result), .overflow(overflow),
        .divZero(div_zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a, b;
        logic [7:0] res;
        logic       ovf, dz, ill;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Signed integer reference of what each operation should return.
    function automatic vec_t model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        vec_t v;
        int sa, sb, p;
        sa = $signed(a);
        sb = $signed(b);
        v.op = o; v.a = a; v.b = b;
        v.res = 8'h00; v.ovf = 1'b0; v.dz = 1'b0; v.ill = 1'b0; v.lat = 10;
        p = sa * sb;
        case (o)
            2'd0: begin v.res = 8'(p); v.ovf = (p < -128) || (p > 127); end
            2'd1: v.res = 8'(p >>> 8);
            default: begin
`ifdef MULDIV_DIVIDER_EN
                if (sb == 0) begin
                    v.lat = 1; v.dz = 1'b1;
                    v.res = (o == 2'd2) ? 8'hFF : a;
                end else if (sa == -128 && sb == -1) begin
                    v.lat = 1; v.ovf = (o == 2'd2);
                    v.res = (o == 2'd2) ? 8'h80 : 8'h00;
                end else begin
                    v.res = (o == 2'd2) ? 8'(sa / sb) : 8'(sa % sb);
                end
`else
                v.lat = 1; v.ill = 1'b1; v.res = 8'h00;
`endif
            end
        endcase
        return v;
    endfunction

    task automatic do_op(input vec_t v, input string name, input bit perturb);
        int lat;
        @(negedge clk);
        start = 1'b1; op = v.op; va = v.a; vb = v.b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        chk({name, "_busy_first"}, int'(busy), int'(v.lat != 1));
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (perturb && lat == 3) begin
                start = 1'b1; op = 2'($urandom); va = 8'($urandom); vb = 8'($urandom);
            end
            if (perturb && lat == 6) start = 1'b0;
        end
        chk({name, "_done"}, int'(done), 1);
        chk({name, "_lat"}, lat, v.lat);
        chk({name, "_busy_at_done"}, int'(busy), 0);
        chk({name, "_res"}, int'(result), int'(v.res));
        if (v.op != 2'd1) chk({name, "_ovf"}, int'(overflow), int'(v.ovf));
        chk({name, "_dz"}, int'(div_zero), int'(v.dz));
        chk({name, "_ill"}, int'(illegal), int'(v.ill));
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, int'(done), 0);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int seen;
        logic [7:0] pick[6];
        pick = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hFE};

        vecs.push_back('{2'd0, 8'h07, 8'hFD, 8'hEB, 1'b0, 1'b0, 1'b0, 10});
        vecs.push_back('{2'd1, 8'h07, 8'hFD, 8'hFF, 1'b0, 1'b0, 1'b0, 10});
        vecs.push_back('{2'd0, 8'h40, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 10});
        vecs.push_back('{2'd1, 8'h40, 8'h04, 8'h01, 1'b0, 1'b0, 1'b0, 10});
        vecs.push_back('{2'd0, 8'h09, 8'h03, 8'h1B, 1'b0, 1'b0, 1'b0, 10});
        vecs.push_back('{2'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 10});
        vecs.push_back('{2'd1, 8'h80, 8'h80, 8'h40, 1'b0, 1'b0, 1'b0, 10});
`ifdef MULDIV_DIVIDER_EN
        vecs.push_back('{2'd2, 8'hF9, 8'h02, 8'hFD, 1'b0, 1'b0, 1'b0, 10});
        vecs.push_back('{2'd3, 8'hF9, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0, 10});
        vecs.push_back('{2'd2, 8'h64, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{2'd2, 8'h80, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{2'd3, 8'h80, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{2'd3, 8'h64, 8'h00, 8'h64, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{2'd2, 8'h80, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0, 10});
`else
        vecs.push_back('{2'd2, 8'h09, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{2'd3, 8'h09, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 1});
`endif

        rst = 1'b1; start = 1'b0; op = 2'd0; va = 8'h00; vb = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_flags", int'({overflow, div_zero, illegal}), 0);
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i]) do_op(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // Start while busy and operand churn mid-RUN must not disturb the accepted op.
        do_op(model(2'd0, 8'h07, 8'hFD), "perturb_mul", 1'b1);
        do_op(model(2'd3, 8'hF9, 8'h02), "perturb_rem", 1'b1);

        for (int n = 0; n < 60; n++) begin
            logic [7:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : 8'($urandom);
            do_op(model(2'($urandom), a, b), $sformatf("rand%0d", n), n[0]);
        end

        // Reset in the middle of RUN aborts without a done pulse.
        do_op(model(2'd0, 8'h07, 8'hFD), "pre_reset", 1'b0);
        @(negedge clk); start = 1'b1; op = 2'd0; va = 8'h40; vb = 8'h04;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_run_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_flags", int'({overflow, div_zero, illegal}), 0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("abort_no_done", seen, 0);

        // Reset wins over a simultaneous start.
        @(negedge clk); rst = 1'b1; start = 1'b1; op = 2'd0; va = 8'h03; vb = 8'h05;
        @(posedge clk); #1;
        chk("rst_prio_busy", int'(busy), 0);
        chk("rst_prio_done", int'(done), 0);
        @(negedge clk); rst = 1'b0; start = 1'b0;

        v = '{2'd0, 8'h03, 8'h05, 8'h0F, 1'b0, 1'b0, 1'b0, 10};
        do_op(v, "post_reset_mul", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/iterative_multiply_divide.md
# iterative_multiply_divide

- Multi-cycle signed multiply/divide responder beside the arithmetic logic unit in the execute stage.
- Decode/control issues a request with `_start`; the block iterates one bit per clock and returns `result`, `overflow` and `divZero` with a one-cycle `done` pulse.
- It covers the four operations the single-cycle ALU cannot: MUL, MULH, DIV, REM.
- Control stalls the pipeline while `busy` is high.

## Interface
Parameters:
- DATA_WIDTH, 8, operand/result width (from `definitions`); must be ≥ 4.
- OP_WIDTH, 2, operation code width.

Ports:
- `_clock`  in  1  rising-edge clock; the only clock.
- `_reset`  in  1  synchronous, active-high reset.
- `_start`  in  1  request strobe; sampled only when `busy`=0.
- `_op`  in  OP_WIDTH  operation: 0 MUL (low half), 1 MULH (signed high half), 2 DIV (signed quotient), 3 REM (signed remainder).
- `_valA`  in  DATA_WIDTH  multiplicand/dividend; two's complement.
- `_valB`  in  DATA_WIDTH  multiplier/divisor; two's complement.
- `busy`  out  1  high from the accept edge until the edge that asserts `done`.
- `done`  out  1  one-cycle pulse; `result`/flags valid.
- `result`  out  DATA_WIDTH  last result; held until the next `done`.
- `overflow`  out  1  MUL: high half ≠ sign extension of low half; DIV: MIN / −1.
- `divZero`  out  1  DIV/REM with `_valB`=0.
- `illegal`  out  1  operation not compiled in (see Configuration).

## Operation
- **States:** IDLE, RUN, FIX, DONE.
- **IDLE → RUN** on `_start`=1: latch |A|, |B|, result signs, `_op`; load counter = DATA_WIDTH−1.
- **IDLE → DONE** (short path) on `_start`=1 in either case:
  - DIV/REM with B=0: result = all-ones for DIV, A for REM; `divZero`=1.
  - DIV/REM with A=MIN and B=−1: result = MIN for DIV, 0 for REM; `overflow`=1 only for DIV.
- **RUN**, one iteration per clock:
  - MUL: shift-add into a 2·DATA_WIDTH unsigned product.
  - DIV/REM: restoring subtract-shift.
  - Counter decrements each clock; RUN → FIX when counter = 0.
- **FIX**, one clock: apply sign.
  - Product negated if sign(A) ≠ sign(B).
  - Quotient negated if signs differ.
  - Remainder takes the sign of A.
  - Select the half/part for `_op`, compute `overflow`, register outputs.
  - FIX → DONE.
- **DONE**, one clock: `done`=1, `busy`=0 → IDLE.
  - `_start` is not accepted in DONE.
  - The next request is accepted in IDLE, at earliest the cycle after `done`.
- **Operand sampling:** `_valA`/`_valB`/`_op` are sampled only at the accept edge; later changes are ignored.
- **Flags:**
  - `result`, `overflow`, `divZero` and `illegal` update only when entering DONE.
  - `overflow`, `divZero` and `illegal` are all cleared at every accept.
- **Reset:**
  - Values: state IDLE, `busy`=0, `done`=0, `result`=0, `overflow`=0, `divZero`=0, `illegal`=0, counter=0.
  - Reset in any state, including mid-RUN, aborts with no `done`.
  - Reset has priority over `_start` in the same cycle.

## Timing
- `busy` rises in the cycle after the accept edge E0.
- Normal path:
  - Iteration edges E1..E_DATA_WIDTH.
  - FIX edge E_DATA_WIDTH+1.
  - `done` high during the cycle after E_DATA_WIDTH+1.
  - Latency: DATA_WIDTH+2 cycles from accept to `done` (10 for DATA_WIDTH=8).
- Short path: `done` is high in the cycle after E0 (latency 1); `busy` stays 0.
- Throughput, normal path: one operation per DATA_WIDTH+3 cycles.
- **Arithmetic width rules:**
  - The internal product is 2·DATA_WIDTH.
  - Magnitudes use DATA_WIDTH+1 bits so that |MIN| is representable.
  - Negation is two's complement at full internal width before truncation.

## Configuration
- Macro: `MULDIV_DIVIDER_EN`.
- **Defined:** full behaviour above.
- **Undefined:**
  - Divider datapath and remainder logic are removed.
  - DIV/REM take the short path: `result`=0, `illegal`=1, `done` after 1 cycle.
  - `divZero` is tied 0.
  - MUL/MULH are unaffected.

## Test plan
DATA_WIDTH=8 throughout.
- MUL 7 × −3 (0x07, 0xFD) → `done` exactly 10 cycles after accept; `result`=0xEB; `overflow`=0. Then MULH with the same operands → `result`=0xFF.
- MUL 0x40 × 0x04 → `result`=0x00, `overflow`=1. MULH with the same operands → `result`=0x01.
- DIV −7 / 2 → `result`=0xFD (−3). REM −7 / 2 → `result`=0xFF (−1). Both with `overflow`=0 and `divZero`=0.
- DIV 100 / 0 → `done` 1 cycle after accept; `result`=0xFF; `divZero`=1. Then DIV 0x80 / 0xFF → `result`=0x80, `overflow`=1.
- Assert `_start` while `busy` → ignored, and operand changes mid-RUN are ignored. Assert `_reset` at iteration 4 → outputs return to 0 and no `done` is seen. A fresh MUL 3 × 5 afterwards → 0x0F.
- Build without `MULDIV_DIVIDER_EN`: DIV 9 / 3 → `illegal`=1, `result`=0, latency 1; MUL 9 × 3 → 0x1B.
